spi_flash_sched: RTL and testbench

Shares the single SPI bus to the M25P16 serial flash between two requesters: sector erase and page program. Grants one request at a time using round-robin arbitration. For each granted request it sequences WREN, then the command frame, then RDSR polling until the write-in-progress (WIP) bit clears. It sits between the user-side control logic and the flash pins, and replaces the per-command controllers that each drove sck/cs_n/mosi directly.

---
 rtl/flash_sched_pkg.sv | 30 +++
 rtl/spi_byte_shifter.sv | 66 ++++++
 rtl/spi_flash_sched.sv | 218 +++++++++++++++++++++
 tb/tb_spi_flash_sched.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_sched_pkg.sv
// Shared opcodes, FSM state encoding and command-frame byte selection for spi_flash_sched.
package flash_sched_pkg;

    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_SE   = 8'hD8;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_RDSR = 8'h05;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WREN,
        ST_GAP1,
        ST_CMD,
        ST_GAP2,
        ST_POLL,
        ST_GAP3
    } state_e;

    // Byte idx of the command frame after the opcode: three address bytes, then data.
    function automatic logic [7:0] cmd_byte(input logic [23:0] addr, input logic [8:0] idx,
                                            input logic [7:0] data);
        case (idx)
            9'd1:    return addr[23:16];
            9'd2:    return addr[15:8];
            9'd3:    return addr[7:0];
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 byte engine: shifts one byte out on mosi and in from miso over 8*CLK_DIV cycles.
// byte_done_o is high during the last cycle of the byte so the next byte can load seamlessly.
module spi_byte_shifter #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] data_i,
    input  logic       miso_i,
    output logic       sck_o,
    output logic       mosi_o,
    output logic       byte_done_o,
    output logic [7:0] rx_byte_o
);

    localparam int HALF = CLK_DIV / 2;
    localparam int DW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic          active_q;
    logic [DW-1:0] div_q;
    logic [2:0]    bit_q;
    logic [7:0]    tx_q;
    logic [7:0]    rx_q;
    logic          sck_q;
    logic          last_tick;

    assign last_tick   = active_q && (div_q == DW'(CLK_DIV - 1));
    assign byte_done_o = last_tick && (bit_q == 3'd7);
    assign sck_o       = sck_q;
    assign mosi_o      = active_q & tx_q[7];
    assign rx_byte_o   = rx_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_q <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            sck_q    <= 1'b0;
        end else if (load_i) begin
            active_q <= 1'b1;
            div_q    <= '0;
            bit_q    <= '0;
            tx_q     <= data_i;
            sck_q    <= 1'b0;
        end else if (active_q) begin
            if (last_tick) begin
                div_q <= '0;
                sck_q <= 1'b0;
                tx_q  <= {tx_q[6:0], 1'b0};
                bit_q <= bit_q + 3'd1;
                if (bit_q == 3'd7) active_q <= 1'b0;
            end else begin
                div_q <= div_q + DW'(1);
                // miso is captured on the same edge that raises sck
                if (div_q == DW'(HALF - 1)) begin
                    sck_q <= 1'b1;
                    rx_q  <= {rx_q[6:0], miso_i};
                end
            end
        end
    end

endmodule

// File: rtl/spi_flash_sched.sv
// Round-robin scheduler for sector erase / page program on one M25P16 SPI bus.
// Optional poll timeout: define FLASH_SCHED_TIMEOUT_EN to enable POLL_MAX status-byte limit and err.
module spi_flash_sched
    import flash_sched_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_GAP   = 8,
    parameter int POLL_MAX = 65535
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        se_req,
    input  logic [23:0] se_addr,
    output logic        se_ack,
    input  logic        pp_req,
    input  logic [23:0] pp_addr,
    input  logic [7:0]  pp_len,
    output logic        pp_ack,
    input  logic [7:0]  wr_data,
    output logic        wr_data_rd,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic        sck,
    output logic        cs_n,
    output logic        mosi,
    input  logic        miso
);

    localparam int GW = $clog2(CS_GAP + 1);

    if (CLK_DIV < 2 || (CLK_DIV % 2) != 0 || CS_GAP < 1 || POLL_MAX < 1) begin : g_bad_cfg
        $error("spi_flash_sched: illegal CLK_DIV/CS_GAP/POLL_MAX");
    end

    state_e        state_q;
    logic          prio_pp_q;
    logic          is_pp_q;
    logic [23:0]   addr_q;
    logic [8:0]    len_q;
    logic [8:0]    byte_q;
    logic [GW-1:0] gap_q;
    logic          se_ack_q, pp_ack_q, done_q, rd_q, busy_q, cs_n_q;

    logic          grant_se, grant_pp, gap_end, cmd_more, poll_more, poll_to;
    logic [8:0]    nxt;
    logic          load, byte_done;
    logic [7:0]    tx_byte, rx_byte;
    logic          unused_rx;

    assign grant_se  = se_req && (!pp_req || !prio_pp_q);
    assign grant_pp  = pp_req && !grant_se;
    assign gap_end   = (gap_q == GW'(CS_GAP - 1));
    assign nxt       = byte_q + 9'd1;
    assign cmd_more  = nxt < (is_pp_q ? 9'd4 + len_q : 9'd4);
    // byte_q==0 means the RDSR opcode just finished, so a status byte always follows
    assign poll_more = (byte_q == 9'd0) || (rx_byte[0] && !poll_to);
    assign unused_rx = ^rx_byte[7:1];

    always_comb begin
        load    = 1'b0;
        tx_byte = 8'h00;
        case (state_q)
            ST_IDLE: if (grant_se || grant_pp) begin
                load    = 1'b1;
                tx_byte = OP_WREN;
            end
            ST_GAP1: if (gap_end) begin
                load    = 1'b1;
                tx_byte = is_pp_q ? OP_PP : OP_SE;
            end
            ST_CMD: if (byte_done && cmd_more) begin
                load    = 1'b1;
                tx_byte = cmd_byte(addr_q, nxt, wr_data);
            end
            ST_GAP2: if (gap_end) begin
                load    = 1'b1;
                tx_byte = OP_RDSR;
            end
            ST_POLL: if (byte_done && poll_more) begin
                load    = 1'b1;
                tx_byte = 8'h00;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            prio_pp_q <= 1'b0;
            is_pp_q   <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            byte_q    <= '0;
            gap_q     <= '0;
            se_ack_q  <= 1'b0;
            pp_ack_q  <= 1'b0;
            done_q    <= 1'b0;
            rd_q      <= 1'b0;
            busy_q    <= 1'b0;
            cs_n_q    <= 1'b1;
        end else begin
            se_ack_q <= 1'b0;
            pp_ack_q <= 1'b0;
            done_q   <= 1'b0;
            rd_q     <= 1'b0;
            case (state_q)
                ST_IDLE: if (grant_se || grant_pp) begin
                    state_q   <= ST_WREN;
                    busy_q    <= 1'b1;
                    cs_n_q    <= 1'b0;
                    se_ack_q  <= grant_se;
                    pp_ack_q  <= grant_pp;
                    is_pp_q   <= grant_pp;
                    prio_pp_q <= grant_se;
                    addr_q    <= grant_pp ? pp_addr : se_addr;
                    len_q     <= (pp_len == 8'd0) ? 9'd256 : {1'b0, pp_len};
                end
                ST_WREN: if (byte_done) begin
                    state_q <= ST_GAP1;
                    cs_n_q  <= 1'b1;
                    gap_q   <= '0;
                end
                ST_GAP1: if (gap_end) begin
                    state_q <= ST_CMD;
                    cs_n_q  <= 1'b0;
                    byte_q  <= '0;
                end else begin
                    gap_q <= gap_q + GW'(1);
                end
                ST_CMD: if (byte_done) begin
                    if (cmd_more) begin
                        byte_q <= nxt;
                        rd_q   <= (nxt >= 9'd4);
                    end else begin
                        state_q <= ST_GAP2;
                        cs_n_q  <= 1'b1;
                        gap_q   <= '0;
                    end
                end
                ST_GAP2: if (gap_end) begin
                    state_q <= ST_POLL;
                    cs_n_q  <= 1'b0;
                    byte_q  <= '0;
                end else begin
                    gap_q <= gap_q + GW'(1);
                end
                ST_POLL: if (byte_done) begin
                    if (poll_more) begin
                        byte_q <= 9'd1;
                    end else begin
                        state_q <= ST_GAP3;
                        cs_n_q  <= 1'b1;
                        done_q  <= 1'b1;
                        gap_q   <= '0;
                    end
                end
                ST_GAP3: if (gap_end) begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end else begin
                    gap_q <= gap_q + GW'(1);
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef FLASH_SCHED_TIMEOUT_EN
    localparam int PW = $clog2(POLL_MAX + 1);

    logic [PW-1:0] poll_q;
    logic          err_q;

    assign poll_to = (byte_q != 9'd0) && rx_byte[0] && (poll_q == PW'(POLL_MAX - 1));
    assign err     = err_q;

    // poll_q counts status bytes already read within the current POLL frame
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            poll_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (state_q != ST_POLL) begin
                poll_q <= '0;
            end else if (byte_done && byte_q != 9'd0) begin
                poll_q <= poll_q + PW'(1);
                err_q  <= poll_to;
            end
        end
    end
`else
    assign poll_to = 1'b0;
    assign err     = 1'b0;
`endif

    spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shift (
        .clk_i      (sys_clk),
        .rst_i      (sys_rst),
        .load_i     (load),
        .data_i     (tx_byte),
        .miso_i     (miso),
        .sck_o      (sck),
        .mosi_o     (mosi),
        .byte_done_o(byte_done),
        .rx_byte_o  (rx_byte)
    );

    assign se_ack     = se_ack_q;
    assign pp_ack     = pp_ack_q;
    assign done       = done_q;
    assign wr_data_rd = rd_q;
    assign busy       = busy_q;
    assign cs_n       = cs_n_q;

endmodule

// File: tb/tb_spi_flash_sched.sv
// Bench for spi_flash_sched: SPI flash slave model, show-ahead FIFO model and frame-level reference.
`timescale 1ns/1ps
module tb_spi_flash_sched;

    localparam int CLK_DIV  = 4;
    localparam int CS_GAP   = 8;
    localparam int POLL_MAX = 16;
    localparam int BYTE_CYC = 8 * CLK_DIV;

    logic        sys_clk = 1'b0, sys_rst = 1'b1;
    logic        se_req = 1'b0, pp_req = 1'b0, miso = 1'b0;
    logic [23:0] se_addr = '0, pp_addr = '0;
    logic [7:0]  pp_len = '0, wr_data = '0;
    logic        se_ack, pp_ack, wr_data_rd, done, err, busy, sck, cs_n, mosi;

    always #10 sys_clk = ~sys_clk;

    spi_flash_sched #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .POLL_MAX(POLL_MAX)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .se_req(se_req), .se_addr(se_addr), .se_ack(se_ack),
        .pp_req(pp_req), .pp_addr(pp_addr), .pp_len(pp_len), .pp_ack(pp_ack),
        .wr_data(wr_data), .wr_data_rd(wr_data_rd),
        .done(done), .err(err), .busy(busy),
        .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso)
    );

    int checks = 0, errors = 0;

    // flash slave: logs non-status bytes and byte count per cs_n-low frame
    logic [7:0] log_q[$];
    int         flen_q[$];
    int         fbits = 0, fbytes = 0, bad_bits = 0, wip_left = 0;
    logic [7:0] fsh = '0, fop = '0;

    always @(negedge cs_n) begin
        fbits  = 0;
        fbytes = 0;
    end
    always @(posedge sck) if (!cs_n) begin
        fsh = {fsh[6:0], mosi};
        fbits++;
        if (fbits % 8 == 0) begin
            if (fbytes == 0) begin
                fop = fsh;
                log_q.push_back(fsh);
            end else if (fop == 8'h05) begin
                if (wip_left > 0) wip_left--;
            end else begin
                log_q.push_back(fsh);
            end
            fbytes++;
        end
    end
    always @(posedge cs_n) begin
        if (fbits % 8 != 0) bad_bits++;
        if (fbits > 0) flen_q.push_back(fbytes);
    end
    always @(negedge sck or negedge cs_n) miso <= (wip_left > 0);

    // show-ahead FIFO
    logic [7:0] fifo_q[$];
    always @(posedge sys_clk) begin
        if (wr_data_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
        wr_data <= (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    end

    // event monitor
    int n_se_ack = 0, n_pp_ack = 0, n_done = 0, n_err = 0, n_rd = 0, n_busy = 0;
    int n_done_bad = 0, n_err_bad = 0;
    int grant_q[$];
    logic prev_cs_n = 1'b1;
    always @(negedge sys_clk) begin
        if (se_ack) begin n_se_ack++; grant_q.push_back(0); end
        if (pp_ack) begin n_pp_ack++; grant_q.push_back(1); end
        if (done) begin
            n_done++;
            if (!(cs_n && !prev_cs_n)) n_done_bad++;
        end
        if (err) begin
            n_err++;
            if (!done) n_err_bad++;
        end
        if (wr_data_rd) n_rd++;
        if (busy) n_busy++;
        prev_cs_n = cs_n;
    end

    // reference: expected frames and busy length from the protocol description
    logic [7:0] exp_log[$];
    int         exp_flen[$];
    logic [7:0] exp_data[$];

    function automatic void exp_cmd(input bit pp, input logic [23:0] a, input int nbytes,
                                    input int nstat);
        exp_log.push_back(8'h06);
        exp_flen.push_back(1);
        exp_log.push_back(pp ? 8'h02 : 8'hD8);
        exp_log.push_back(a[23:16]);
        exp_log.push_back(a[15:8]);
        exp_log.push_back(a[7:0]);
        if (pp) for (int i = 0; i < nbytes; i++) exp_log.push_back(exp_data.pop_front());
        exp_flen.push_back(pp ? 4 + nbytes : 4);
        exp_log.push_back(8'h05);
        exp_flen.push_back(1 + nstat);
    endfunction

    function automatic int busy_len(input bit pp, input int nbytes, input int nstat);
        return BYTE_CYC + CS_GAP + (pp ? 4 + nbytes : 4) * BYTE_CYC + CS_GAP
               + (1 + nstat) * BYTE_CYC + CS_GAP;
    endfunction

    function automatic int log_diff();
        int d = 0;
        if (log_q.size() != exp_log.size()) d++;
        else foreach (exp_log[i]) if (log_q[i] !== exp_log[i]) d++;
        if (flen_q.size() != exp_flen.size()) d++;
        else foreach (exp_flen[i]) if (flen_q[i] != exp_flen[i]) d++;
        return d;
    endfunction

    task automatic clear_logs();
        log_q.delete(); flen_q.delete(); exp_log.delete(); exp_flen.delete();
        exp_data.delete(); grant_q.delete();
    endtask

    task automatic do_reset();
        se_req = 0; pp_req = 0; sys_rst = 1;
        repeat (3) @(negedge sys_clk);
        sys_rst = 0;
    endtask

    task automatic issue(input bit pp, input logic [23:0] a, input logic [7:0] len8,
                         output int ack_lat, output bit hung);
        @(negedge sys_clk);
        if (pp) begin pp_req = 1; pp_addr = a; pp_len = len8; end
        else begin se_req = 1; se_addr = a; end
        ack_lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge sys_clk);
            if (pp ? pp_ack : se_ack) begin ack_lat = k; break; end
        end
        se_req = 0; pp_req = 0;
        hung = 1;
        for (int k = 0; k < 20000; k++) begin
            if (!busy) begin hung = 0; break; end
            @(negedge sys_clk);
        end
    endtask

    task automatic test_reset();
        sys_rst = 1;
        repeat (3) @(negedge sys_clk);
        checks++;
        if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n got %b want 1", cs_n); end
        checks++;
        if ({sck, mosi, busy, se_ack, pp_ack, done, err, wr_data_rd} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outs got %b want 00000000",
                     {sck, mosi, busy, se_ack, pp_ack, done, err, wr_data_rd});
        end
        sys_rst = 0;
    endtask

    task automatic test_erase(input int wip, input logic [23:0] a);
        int lat, s_se, s_pp, s_done, s_rd, s_busy, s_bad, d;
        bit hung;
        clear_logs();
        wip_left = wip;
        s_se = n_se_ack; s_pp = n_pp_ack; s_done = n_done; s_rd = n_rd; s_busy = n_busy; s_bad = n_done_bad;
        issue(0, a, 8'h00, lat, hung);
        exp_cmd(0, a, 0, wip + 1);
        checks++;
        if (hung || lat != 1) begin errors++; $display("FAIL erase_ack_latency got %0d hung %0d want 1", lat, hung); end
        checks++;
        if (n_se_ack - s_se != 1 || n_pp_ack != s_pp) begin
            errors++; $display("FAIL erase_acks got se %0d pp %0d want 1 0", n_se_ack - s_se, n_pp_ack - s_pp);
        end
        checks++;
        if (n_done - s_done != 1 || n_done_bad != s_bad) begin
            errors++; $display("FAIL erase_done got %0d misaligned %0d want 1 0", n_done - s_done, n_done_bad - s_bad);
        end
        checks++;
        d = log_diff();
        if (d != 0) begin errors++; $display("FAIL erase_frames addr %h got %0d diffs want 0", a, d); end
        checks++;
        if (n_busy - s_busy != busy_len(0, 0, wip + 1) || n_rd != s_rd) begin
            errors++; $display("FAIL erase_busy got %0d cycles rd %0d want %0d cycles rd 0",
                               n_busy - s_busy, n_rd - s_rd, busy_len(0, 0, wip + 1));
        end
    endtask

    task automatic test_program(input logic [23:0] a, input logic [7:0] len8, input bit fixed);
        int lat, nb, s_rd, s_busy, s_done, d;
        bit hung;
        logic [7:0] b;
        clear_logs();
        wip_left = 0;
        nb = (len8 == 0) ? 256 : int'(len8);
        for (int i = 0; i < nb; i++) begin
            b = fixed ? 8'(8'hAA + 8'(i * 17)) : 8'($urandom);
            fifo_q.push_back(b);
            exp_data.push_back(b);
        end
        repeat (2) @(negedge sys_clk);
        s_rd = n_rd; s_busy = n_busy; s_done = n_done;
        issue(1, a, len8, lat, hung);
        exp_cmd(1, a, nb, 1);
        checks++;
        if (hung || lat != 1) begin errors++; $display("FAIL prog_ack_latency got %0d hung %0d want 1", lat, hung); end
        checks++;
        d = log_diff();
        if (d != 0) begin errors++; $display("FAIL prog_frames len %0d got %0d diffs want 0", nb, d); end
        checks++;
        if (n_rd - s_rd != nb || fifo_q.size() != 0) begin
            errors++; $display("FAIL prog_rd_pulses got %0d left %0d want %0d left 0", n_rd - s_rd, fifo_q.size(), nb);
        end
        checks++;
        if (n_busy - s_busy != busy_len(1, nb, 1) || n_done - s_done != 1) begin
            errors++; $display("FAIL prog_busy got %0d done %0d want %0d done 1",
                               n_busy - s_busy, n_done - s_done, busy_len(1, nb, 1));
        end
        fifo_q.delete();
    endtask

    task automatic test_contention(input int rounds_done);
        logic [23:0] ea, pa;
        logic [7:0]  pl;
        int exp_order[$];
        bit pend_se, pend_pp, last_pp, got;
        int d;
        clear_logs();
        wip_left = 0;
        ea = 24'($urandom); pa = 24'($urandom); pl = 8'($urandom_range(1, 6));
        for (int i = 0; i < int'(pl); i++) begin
            fifo_q.push_back(8'($urandom));
            exp_data.push_back(fifo_q[i]);
        end
        // model: after reset or after a program grant, erase has priority
        last_pp = 1; pend_se = 1; pend_pp = 1;
        while (pend_se || pend_pp) begin
            if (pend_se && (!pend_pp || last_pp)) begin exp_order.push_back(0); pend_se = 0; last_pp = 0; end
            else begin exp_order.push_back(1); pend_pp = 0; last_pp = 1; end
        end
        foreach (exp_order[i]) exp_cmd(exp_order[i] == 1, exp_order[i] == 1 ? pa : ea, int'(pl), 1);
        @(negedge sys_clk);
        se_req = 1; se_addr = ea; pp_req = 1; pp_addr = pa; pp_len = pl;
        got = 0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge sys_clk);
            if (se_ack) se_req = 0;
            if (pp_ack) pp_req = 0;
            if (!se_req && !pp_req && !busy) begin got = 1; break; end
        end
        se_req = 0; pp_req = 0;
        checks++;
        if (!got || grant_q.size() != 2 || grant_q[0] != exp_order[0] || grant_q[1] != exp_order[1]) begin
            errors++;
            $display("FAIL contention_order round %0d got %0d grants first %0d want 2 grants first %0d",
                     rounds_done, grant_q.size(), grant_q.size() > 0 ? grant_q[0] : -1, exp_order[0]);
        end
        checks++;
        d = log_diff();
        if (d != 0) begin errors++; $display("FAIL contention_frames round %0d got %0d diffs want 0", rounds_done, d); end
        fifo_q.delete();
    endtask

    task automatic test_reset_mid();
        int s_done, lat;
        bit got;
        clear_logs();
        wip_left = 0;
        @(negedge sys_clk);
        se_req = 1; se_addr = 24'hABCDEF;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge sys_clk);
            if (se_ack) begin got = 1; break; end
        end
        se_req = 0;
        // land inside the second byte of the command frame
        repeat (BYTE_CYC + CS_GAP + BYTE_CYC + 10) @(negedge sys_clk);
        checks++;
        if (!got || cs_n !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL midreset_pre got ack %0d cs_n %b busy %b want 1 0 1", got, cs_n, busy);
        end
        s_done = n_done;
        sys_rst = 1;
        @(negedge sys_clk);
        checks++;
        if ({cs_n, sck, busy, mosi} !== 4'b1000) begin
            errors++; $display("FAIL midreset_outs got %b want 1000", {cs_n, sck, busy, mosi});
        end
        sys_rst = 0;
        repeat (400) @(negedge sys_clk);
        checks++;
        if (n_done != s_done || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_quiet got done %0d busy %b want 0 0", n_done - s_done, busy);
        end
        bad_bits = 0;
        test_erase(1, 24'($urandom));
        lat = bad_bits;
        checks++;
        if (lat != 0) begin errors++; $display("FAIL midreset_partial_frames got %0d want 0", lat); end
    endtask

`ifdef FLASH_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int lat, s_err, s_ebad, s_busy, d;
        bit hung;
        clear_logs();
        wip_left = 100000;
        s_err = n_err; s_ebad = n_err_bad; s_busy = n_busy;
        issue(0, 24'h0F00F0, 8'h00, lat, hung);
        exp_cmd(0, 24'h0F00F0, 0, POLL_MAX);
        wip_left = 0;
        checks++;
        if (hung || n_err - s_err != 1 || n_err_bad != s_ebad) begin
            errors++; $display("FAIL timeout_err got %0d unpaired %0d want 1 0", n_err - s_err, n_err_bad - s_ebad);
        end
        checks++;
        d = log_diff();
        if (d != 0) begin errors++; $display("FAIL timeout_frames got %0d diffs want 0", d); end
        checks++;
        if (n_busy - s_busy != busy_len(0, 0, POLL_MAX)) begin
            errors++; $display("FAIL timeout_busy got %0d want %0d", n_busy - s_busy, busy_len(0, 0, POLL_MAX));
        end
    endtask
`else
    task automatic test_err_tied();
        checks++;
        if (n_err != 0) begin errors++; $display("FAIL err_tied got %0d pulses want 0", n_err); end
    endtask
`endif

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_contention(0);
        test_contention(1);
        test_erase(0, 24'h012345);
        for (int i = 0; i < 3; i++) test_erase($urandom_range(0, 3), 24'($urandom));
        test_erase(3, 24'h00FF00);
        test_program(24'h000100, 8'd4, 1'b1);
        for (int i = 0; i < 2; i++) test_program(24'($urandom), 8'($urandom_range(1, 16)), 1'b0);
        test_program(24'($urandom), 8'd0, 1'b0);
        test_reset_mid();
`ifdef FLASH_SCHED_TIMEOUT_EN
        test_timeout();
`else
        test_err_tied();
`endif
        checks++;
        if (bad_bits != 0) begin errors++; $display("FAIL frame_bit_alignment got %0d want 0", bad_bits); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
